// File: rtl/regfile_port_scheduler_if.sv
// ---------------------------------------------------------------------------
// regfile_port_scheduler_if
//
// Writeback request bus between NUM_REQ writeback units and the register
// file port scheduler. Each requester owns one slice of the packed vectors.
//
//   req_valid [NUM_REQ]                requester i has a write pending
//   req_addr  [NUM_REQ*REG_ADDR_SIZE]  destination of requester i
//                                      (slice i at [i*REG_ADDR_SIZE +: REG_ADDR_SIZE])
//   req_data  [NUM_REQ*WORD_SIZE]      write data of requester i (slice i)
//   req_ready [NUM_REQ]                one-hot grant; transfer on valid & ready
//
// master : the writeback units (drive valid/addr/data, observe ready)
// slave  : the scheduler (observe valid/addr/data, drive ready)
// ---------------------------------------------------------------------------
interface regfile_port_scheduler_if #(
  parameter int WORD_SIZE     = 64,
  parameter int REG_ADDR_SIZE = 4,
  parameter int NUM_REQ       = 2
);
  logic [NUM_REQ-1:0]               req_valid;
  logic [NUM_REQ*REG_ADDR_SIZE-1:0] req_addr;
  logic [NUM_REQ*WORD_SIZE-1:0]     req_data;
  logic [NUM_REQ-1:0]               req_ready;

  modport master (
    output req_valid,
    output req_addr,
    output req_data,
    input  req_ready
  );

  modport slave (
    input  req_valid,
    input  req_addr,
    input  req_data,
    output req_ready
  );
endinterface

// File: rtl/regfile_port_scheduler.sv
// ---------------------------------------------------------------------------
// regfile_port_scheduler
//
// Owns the single write port of the shared register file. Writeback units
// compete for it through a round-robin arbiter; the winning request is
// registered onto rf_write/rf_data and commits in the register file one
// edge later. Alongside, a pending-write scoreboard lets the issue stage
// detect read-after-write hazards on two read addresses.
//
// Ports:
//   clk, rst     clock and synchronous active-high reset
//   wb           writeback request bus (slave side)
//   issue_valid  issue stage reserves destination issue_addr this cycle
//   issue_addr   destination being reserved
//   flush        drop every reservation
//   r1, r2       read addresses under hazard check
//   busy1, busy2 r1 / r2 has a pending write (combinational from state)
//   rf_en        register file enable, held high outside reset
//   rf_write     register file write address (0 = idle, write discarded)
//   rf_data      register file write data
// ---------------------------------------------------------------------------
module regfile_port_scheduler #(
  parameter int WORD_SIZE     = 64,
  parameter int REG_ADDR_SIZE = 4,
  parameter int NUM_REQ       = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  regfile_port_scheduler_if.slave  wb,
  input  logic                     issue_valid,
  input  logic [REG_ADDR_SIZE-1:0] issue_addr,
  input  logic                     flush,
  input  logic [REG_ADDR_SIZE-1:0] r1,
  input  logic [REG_ADDR_SIZE-1:0] r2,
  output logic                     busy1,
  output logic                     busy2,
  output logic                     rf_en,
  output logic [REG_ADDR_SIZE-1:0] rf_write,
  output logic [WORD_SIZE-1:0]     rf_data
);

  localparam int PTR_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int NUM_REGS = 1 << REG_ADDR_SIZE;

  // Pointer holds the most recently granted requester; scanning starts one past it.
  logic [PTR_W-1:0]         ptr_q, ptr_d;
  logic                     rf_en_q, rf_en_d;
  logic [REG_ADDR_SIZE-1:0] rf_write_q, rf_write_d;
  logic [WORD_SIZE-1:0]     rf_data_q, rf_data_d;
  logic [NUM_REGS-1:0]      sb_q, sb_d;

  logic [NUM_REQ-1:0]       grant;
  logic [PTR_W-1:0]         grant_idx;
  logic [PTR_W-1:0]         scan_idx;
  logic                     found;
  logic [REG_ADDR_SIZE-1:0] sel_addr;
  logic [WORD_SIZE-1:0]     sel_data;

  // ---- arbitration stage: round-robin scan from ptr_q+1 ----
  always_comb begin
    grant     = '0;
    grant_idx = ptr_q;
    scan_idx  = '0;
    found     = 1'b0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      scan_idx = PTR_W'((int'(ptr_q) + i) % NUM_REQ);
      // Ready is derived from valids and the pointer only, never from ready itself.
      if (!found && !rst && wb.req_valid[scan_idx]) begin
        found           = 1'b1;
        grant[scan_idx] = 1'b1;
        grant_idx       = scan_idx;
      end
    end
  end

  assign wb.req_ready = grant;

  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        sel_addr = wb.req_addr[i*REG_ADDR_SIZE +: REG_ADDR_SIZE];
        sel_data = wb.req_data[i*WORD_SIZE +: WORD_SIZE];
      end
    end
  end

  // ---- next-state stage: write port register and scoreboard ----
  always_comb begin
    rf_en_d    = 1'b1;
    rf_write_d = found ? sel_addr : '0;
    rf_data_d  = found ? sel_data : '0;
    ptr_d      = found ? grant_idx : ptr_q;

    sb_d = sb_q;
    // The write sitting in rf_write commits this edge, so its reservation retires.
    sb_d[rf_write_q] = 1'b0;
    // A same-edge reservation of that address is a newer writer and must win.
    if (issue_valid) begin
      sb_d[issue_addr] = 1'b1;
    end
    if (flush) begin
      sb_d = '0;
    end
    sb_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rf_en_q    <= 1'b0;
      rf_write_q <= '0;
      rf_data_q  <= '0;
      ptr_q      <= PTR_W'(NUM_REQ - 1);
      sb_q       <= '0;
    end else begin
      rf_en_q    <= rf_en_d;
      rf_write_q <= rf_write_d;
      rf_data_q  <= rf_data_d;
      ptr_q      <= ptr_d;
      sb_q       <= sb_d;
    end
  end

  // ---- output stage ----
  assign rf_en    = rf_en_q;
  assign rf_write = rf_write_q;
  assign rf_data  = rf_data_q;
  // Entry 0 of the scoreboard is always clear, so r=0 never reports busy.
  assign busy1    = sb_q[r1];
  assign busy2    = sb_q[r2];

endmodule

// File: tb/tb_regfile_port_scheduler.sv
module tb_regfile_port_scheduler;
  localparam int W = 64;
  localparam int A = 4;
  localparam int N = 2;
  localparam int R = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic         issue_valid;
  logic [A-1:0] issue_addr;
  logic         flush;
  logic [A-1:0] r1, r2;
  logic         busy1, busy2, rf_en;
  logic [A-1:0] rf_write;
  logic [W-1:0] rf_data;

  regfile_port_scheduler_if #(.WORD_SIZE(W), .REG_ADDR_SIZE(A), .NUM_REQ(N)) bus ();

  regfile_port_scheduler #(.WORD_SIZE(W), .REG_ADDR_SIZE(A), .NUM_REQ(N)) dut (
    .clk(clk), .rst(rst), .wb(bus),
    .issue_valid(issue_valid), .issue_addr(issue_addr), .flush(flush),
    .r1(r1), .r2(r2), .busy1(busy1), .busy2(busy2),
    .rf_en(rf_en), .rf_write(rf_write), .rf_data(rf_data)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: last granted index, set of pending destinations,
  // and the write currently presented to the register file.
  int           m_last;
  bit           m_sb [R];
  bit           m_en;
  logic [A-1:0] m_wr;
  logic [W-1:0] m_data;

  function automatic int exp_grant();
    if (rst) return -1;
    for (int k = 1; k <= N; k++) begin
      int j;
      j = (m_last + k) % N;
      if (bus.req_valid[j]) return j;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] exp_ready();
    logic [N-1:0] r;
    int g;
    r = '0;
    g = exp_grant();
    if (g >= 0) r[g] = 1'b1;
    return r;
  endfunction

  // Advance the model with the inputs applied this cycle, then step the clock.
  task automatic tick();
    int g;
    g = exp_grant();
    if (rst) begin
      m_en = 1'b0; m_wr = '0; m_data = '0; m_last = N - 1;
      foreach (m_sb[i]) m_sb[i] = 1'b0;
    end else begin
      if (m_wr != 0) m_sb[m_wr] = 1'b0;
      if (issue_valid && issue_addr != 0) m_sb[issue_addr] = 1'b1;
      if (flush) foreach (m_sb[i]) m_sb[i] = 1'b0;
      if (g >= 0) begin
        m_wr = bus.req_addr[g*A +: A]; m_data = bus.req_data[g*W +: W]; m_last = g;
      end else begin
        m_wr = '0; m_data = '0;
      end
      m_en = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.req_valid = '0; bus.req_addr = '0; bus.req_data = '0;
    issue_valid = 1'b0; issue_addr = '0; flush = 1'b0; r1 = '0; r2 = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    bus.req_valid = 2'b11; bus.req_addr = {4'd6, 4'd5};
    @(negedge clk);
    total++; if (bus.req_ready !== 2'b00) begin bad++; $display("FAIL reset_ready got=%b exp=00", bus.req_ready); end
    tick();
    rst = 1'b0; bus.req_valid = '0; r1 = 4'd7; r2 = 4'd15;
    @(negedge clk);
    total++; if (rf_en !== 1'b0) begin bad++; $display("FAIL reset_rf_en got=%b exp=0", rf_en); end
    total++; if (rf_write !== 4'd0) begin bad++; $display("FAIL reset_rf_write got=%0d exp=0", rf_write); end
    total++; if (rf_data !== 64'd0) begin bad++; $display("FAIL reset_rf_data got=%h exp=0", rf_data); end
    total++; if ({busy1, busy2} !== 2'b00) begin bad++; $display("FAIL reset_busy got=%b exp=00", {busy1, busy2}); end
    tick();
  endtask

  task automatic test_single_write();
    do_reset();
    bus.req_valid = 2'b01; bus.req_addr = {4'd0, 4'd3}; bus.req_data = {64'd0, 64'hAA};
    @(negedge clk);
    total++; if (bus.req_ready !== 2'b01) begin bad++; $display("FAIL single_ready got=%b exp=01", bus.req_ready); end
    total++; if (rf_write !== 4'd0) begin bad++; $display("FAIL single_pre_write got=%0d exp=0", rf_write); end
    tick();
    bus.req_valid = '0;
    @(negedge clk);
    total++; if (rf_write !== 4'd3) begin bad++; $display("FAIL single_rf_write got=%0d exp=3", rf_write); end
    total++; if (rf_data !== 64'hAA) begin bad++; $display("FAIL single_rf_data got=%h exp=aa", rf_data); end
    total++; if (rf_en !== 1'b1) begin bad++; $display("FAIL single_rf_en got=%b exp=1", rf_en); end
    total++; if (bus.req_ready !== 2'b00) begin bad++; $display("FAIL single_idle_ready got=%b exp=00", bus.req_ready); end
    tick();
    @(negedge clk);
    total++; if (rf_write !== 4'd0 || rf_data !== 64'd0) begin bad++; $display("FAIL single_idle got=%0d/%h exp=0/0", rf_write, rf_data); end
    total++; if (rf_en !== 1'b1) begin bad++; $display("FAIL single_en_hold got=%b exp=1", rf_en); end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [N-1:0] er;
    do_reset();
    bus.req_valid = 2'b11; bus.req_addr = {4'd6, 4'd5}; bus.req_data = {64'h2222, 64'h1111};
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      er = (k % 2 == 0) ? 2'b01 : 2'b10;
      total++; if (bus.req_ready !== er) begin bad++; $display("FAIL b2b_ready[%0d] got=%b exp=%b", k, bus.req_ready, er); end
      if (k >= 1) begin
        total++;
        if (rf_write !== (((k - 1) % 2 == 0) ? 4'd5 : 4'd6) || rf_data !== (((k - 1) % 2 == 0) ? 64'h1111 : 64'h2222)) begin
          bad++; $display("FAIL b2b_write[%0d] got=%0d/%h", k, rf_write, rf_data);
        end
      end
      tick();
    end
    bus.req_valid = '0;
  endtask

  task automatic test_hazard();
    do_reset();
    issue_valid = 1'b1; issue_addr = 4'd7; r1 = 4'd7;
    @(negedge clk);
    total++; if (busy1 !== 1'b0) begin bad++; $display("FAIL hazard_no_bypass got=%b exp=0", busy1); end
    tick();
    issue_valid = 1'b0;
    @(negedge clk);
    total++; if (busy1 !== 1'b1) begin bad++; $display("FAIL hazard_set got=%b exp=1", busy1); end
    tick();
    bus.req_valid = 2'b10; bus.req_addr = {4'd7, 4'd0}; bus.req_data = {64'h77, 64'd0};
    @(negedge clk);
    total++; if (bus.req_ready !== 2'b10) begin bad++; $display("FAIL hazard_ready got=%b exp=10", bus.req_ready); end
    tick();
    bus.req_valid = '0;
    @(negedge clk);
    total++; if (rf_write !== 4'd7 || busy1 !== 1'b1) begin bad++; $display("FAIL hazard_commit got=%0d/%b exp=7/1", rf_write, busy1); end
    tick();
    @(negedge clk);
    total++; if (busy1 !== 1'b0) begin bad++; $display("FAIL hazard_clear got=%b exp=0", busy1); end
    tick();
  endtask

  task automatic test_set_wins();
    do_reset();
    issue_valid = 1'b1; issue_addr = 4'd7; r1 = 4'd7;
    tick();
    issue_valid = 1'b0;
    bus.req_valid = 2'b01; bus.req_addr = {4'd0, 4'd7}; bus.req_data = {64'd0, 64'h77};
    tick();
    bus.req_valid = '0; issue_valid = 1'b1; issue_addr = 4'd7;
    @(negedge clk);
    total++; if (rf_write !== 4'd7 || busy1 !== 1'b1) begin bad++; $display("FAIL setwins_pre got=%0d/%b exp=7/1", rf_write, busy1); end
    tick();
    issue_valid = 1'b0;
    @(negedge clk);
    total++; if (busy1 !== 1'b1) begin bad++; $display("FAIL setwins_hold got=%b exp=1", busy1); end
    tick();
    issue_valid = 1'b1; issue_addr = 4'd0; r1 = 4'd0; r2 = 4'd0;
    tick();
    issue_valid = 1'b0;
    @(negedge clk);
    total++; if ({busy1, busy2} !== 2'b00) begin bad++; $display("FAIL setwins_zero got=%b exp=00", {busy1, busy2}); end
    tick();
  endtask

  task automatic test_flush();
    do_reset();
    issue_valid = 1'b1;
    issue_addr = 4'd2; tick();
    issue_addr = 4'd4; tick();
    issue_addr = 4'd9; tick();
    issue_valid = 1'b0; r1 = 4'd2; r2 = 4'd4;
    @(negedge clk);
    total++; if ({busy1, busy2} !== 2'b11) begin bad++; $display("FAIL flush_pre got=%b exp=11", {busy1, busy2}); end
    r1 = 4'd9; #1;
    total++; if (busy1 !== 1'b1) begin bad++; $display("FAIL flush_pre9 got=%b exp=1", busy1); end
    flush = 1'b1; issue_valid = 1'b1; issue_addr = 4'd4;
    tick();
    flush = 1'b0; issue_valid = 1'b0; r1 = 4'd2; r2 = 4'd4;
    @(negedge clk);
    total++; if ({busy1, busy2} !== 2'b00) begin bad++; $display("FAIL flush_post got=%b exp=00", {busy1, busy2}); end
    r1 = 4'd9; #1;
    total++; if (busy1 !== 1'b0) begin bad++; $display("FAIL flush_post9 got=%b exp=0", busy1); end
    tick();
  endtask

  task automatic test_reset_mid();
    do_reset();
    bus.req_valid = 2'b11; bus.req_addr = {4'd6, 4'd5}; bus.req_data = {64'h66, 64'h55};
    tick();
    bus.req_valid = 2'b01; bus.req_addr = {4'd0, 4'd5}; issue_valid = 1'b1; issue_addr = 4'd5;
    tick();
    bus.req_valid = 2'b11; bus.req_addr = {4'd6, 4'd5}; issue_valid = 1'b0; rst = 1'b1; r1 = 4'd5;
    @(negedge clk);
    total++; if (rf_write !== 4'd5 || bus.req_ready !== 2'b00) begin bad++; $display("FAIL rstmid_pre got=%0d/%b exp=5/00", rf_write, bus.req_ready); end
    tick();
    rst = 1'b0;
    @(negedge clk);
    total++; if (rf_en !== 1'b0 || rf_write !== 4'd0) begin bad++; $display("FAIL rstmid_out got=%b/%0d exp=0/0", rf_en, rf_write); end
    total++; if (busy1 !== 1'b0) begin bad++; $display("FAIL rstmid_sb got=%b exp=0", busy1); end
    total++; if (bus.req_ready !== 2'b01) begin bad++; $display("FAIL rstmid_ptr got=%b exp=01", bus.req_ready); end
    tick();
    bus.req_valid = '0;
    @(negedge clk);
    total++; if (rf_write !== 4'd5 || rf_en !== 1'b1) begin bad++; $display("FAIL rstmid_replay got=%0d/%b exp=5/1", rf_write, rf_en); end
    tick();
  endtask

  task automatic test_random();
    bit hold [N];
    int g;
    do_reset();
    foreach (hold[i]) hold[i] = 1'b0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      for (int i = 0; i < N; i++) begin
        if (!hold[i]) begin
          bus.req_valid[i]         = ($urandom_range(2) != 0);
          bus.req_addr[i*A +: A]   = A'($urandom_range(R - 1));
          bus.req_data[i*W +: W]   = {$urandom, $urandom};
        end
      end
      rst         = ($urandom_range(49) == 0);
      issue_valid = $urandom_range(1) == 1;
      issue_addr  = A'($urandom_range(R - 1));
      flush       = ($urandom_range(24) == 0);
      r1          = A'($urandom_range(R - 1));
      r2          = A'($urandom_range(R - 1));
      @(negedge clk);
      total++; if (bus.req_ready !== exp_ready()) begin bad++; $display("FAIL rnd_ready c%0d got=%b exp=%b", cyc, bus.req_ready, exp_ready()); end
      total++; if (busy1 !== m_sb[r1] || busy2 !== m_sb[r2]) begin bad++; $display("FAIL rnd_busy c%0d got=%b%b exp=%b%b", cyc, busy1, busy2, m_sb[r1], m_sb[r2]); end
      total++; if (rf_en !== m_en) begin bad++; $display("FAIL rnd_en c%0d got=%b exp=%b", cyc, rf_en, m_en); end
      total++; if (rf_write !== m_wr || rf_data !== m_data) begin bad++; $display("FAIL rnd_write c%0d got=%0d/%h exp=%0d/%h", cyc, rf_write, rf_data, m_wr, m_data); end
      g = exp_grant();
      for (int i = 0; i < N; i++) hold[i] = bus.req_valid[i] && (g != i);
      tick();
    end
    rst = 1'b0;
    idle_inputs();
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    m_last = N - 1; m_en = 1'b0; m_wr = '0; m_data = '0;
    foreach (m_sb[i]) m_sb[i] = 1'b0;
    #1;
    test_reset();
    test_single_write();
    test_back_to_back();
    test_hazard();
    test_set_wins();
    test_flush();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached total=%0d bad=%0d", total, bad);
    $fatal(1);
  end
endmodule
